cost_arb: RTL
=============

COST_ARB -- requirements
Module: cost_arb

Interface
REQ-001 Parameter MAX_BURST, default 8: maximum consecutive locked beats per requester before forced release.
REQ-002 Parameter COST_W, default 7: cost data width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  requester i has a valid read request.
REQ-006 W0/J0, W1/J1  input  3 each  requester i worker/job index.
REQ-007 lock0, lock1  input  1 each  requester i holds the table after this beat.
REQ-008 gnt0, gnt1  output  1 each  combinational accept; transfer = req_i & gnt_i.
REQ-009 rvalid0, rvalid1  output  1 each  registered; rdata belongs to requester i.
REQ-010 rdata  output  COST_W  registered cost returned to requesters.
REQ-011 W, J  output  3 each  registered table address.
REQ-012 Cost  input  COST_W  table data, combinational from W/J, valid the cycle W/J are driven.

Function
REQ-013 At most one gnt SHALL be high per cycle; gnt_i SHALL be 0 when req_i is 0 or RST is 1.
REQ-014 FSM states FREE, LOCK0, LOCK1; reset state FREE.
REQ-015 FREE, one request: grant it; FREE, both: grant requester not granted last (last_gnt, reset value 1 so requester 0 wins first).
REQ-016 LOCKi: gnt_i = req_i; gnt of the other requester SHALL be 0 even if requester i is idle.
REQ-017 Transfer by i with lock_i=1 in FREE -> LOCKi, beat counter loaded to 1.
REQ-018 Transfer by i in LOCKi: lock_i=0 -> FREE; lock_i=1 -> counter+1; counter reaching MAX_BURST -> FREE regardless of lock_i.
REQ-019 Forced release SHALL set last_gnt=i so the other requester wins the next contended cycle.
REQ-020 Every transfer SHALL update last_gnt to the granted index.
REQ-021 Transfer in cycle t: W/J SHALL hold W_i/J_i from t+1; rdata=Cost captured end of t+1; rvalid_i high in t+2 only; latency 2.
REQ-022 Throughput one transfer per cycle; back-to-back transfers SHALL yield back-to-back rvalid pulses in issue order, correct requester tag each.
REQ-023 No transfer in cycle t -> W/J hold previous values, no rvalid in t+2.
REQ-024 rdata SHALL hold its value when no rvalid is asserted.
REQ-025 Requester i SHALL keep req_i/W_i/J_i/lock_i stable until transfer; arbiter does not check this.

Reset
REQ-026 RST=1: state FREE, last_gnt=1, beat counter 0, W=0, J=0, rdata=0, rvalid0=rvalid1=0, gnt0=gnt1=0.
REQ-027 RST mid-burst or mid-pipeline SHALL discard in-flight reads; no rvalid in any cycle after RST deasserts for requests accepted before RST.

Structure
REQ-028 Shared package holds COST_W, index width 3, MAX_BURST default, FSM state encoding.
REQ-029 One sub-module cost_arb_rr: 2-way round-robin picker (req vector, last_gnt -> one-hot grant), combinational.
REQ-030 Pipeline tag (valid + requester id) SHALL be a 2-stage shift register alongside address/data registers.

Verification
REQ-031 Reset, req0=1 W0=2 J0=5, table(2,5)=17 -> gnt0 cycle 0, W=2 J=5 cycle 1, rvalid0=1 rdata=17 cycle 2.
REQ-032 req0 and req1 both high 4 cycles, lock=0 -> grants alternate 0,1,0,1; rvalid tags alternate likewise.
REQ-033 req0 lock0=1 for 3 beats then lock0=0, req1 high throughout -> gnt1 low for 4 beats, gnt1 high next cycle.
REQ-034 req0 lock0=1 held 10 beats, req1 high -> forced release after beat 8, beat 9 granted to requester 1.
REQ-035 RST pulsed one cycle after a transfer -> rvalid0/rvalid1 stay 0, W=J=0, next contended grant to requester 0.
REQ-036 Sweep W0=0..7 with fixed J0=p[i] from a permutation -> eight rvalid0 pulses, rdata sum equals reference cost sum.

Source files
------------

// File: rtl/cost_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cost_arb_pkg
//  Purpose  : Shared widths, defaults, FSM encoding and pipeline tag type
//             for the two-requester cost-table arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package cost_arb_pkg;

  localparam int COST_W_DEF    = 7;  // default cost data width
  localparam int IDX_W         = 3;  // worker/job index width
  localparam int MAX_BURST_DEF = 8;  // default locked-burst length limit

  // Arbiter ownership states
  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // One pipeline tag: a read is in flight and which requester owns it
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/cost_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module   : cost_arb_rr
//  Purpose  : Two-way round-robin picker. A lone request always wins; when
//             both request, the one not granted last wins.
//  Revision : 1.0  initial release
// ============================================================================
module cost_arb_rr (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // One-hot pick; contention resolved against the last granted index
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cost_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cost_arb
//  Purpose  : Arbitrates two requesters onto a shared combinational cost
//             table. Supports locked bursts (bounded by MAX_BURST) and returns
//             the looked-up cost two cycles after each transfer, tagged with
//             the owning requester.
//  Revision : 1.0  initial release
// ============================================================================
import cost_arb_pkg::*;

module cost_arb #(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int COST_W    = COST_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic [IDX_W-1:0]  W0,
  input  logic [IDX_W-1:0]  J0,
  input  logic              lock0,
  input  logic              req1,
  input  logic [IDX_W-1:0]  W1,
  input  logic [IDX_W-1:0]  J1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [COST_W-1:0] rdata,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state;
  logic             last_gnt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_inc;

  logic [1:0]       rr_gnt;
  logic [1:0]       gnt_v;
  logic             xfer;
  logic             xfer_id;
  logic             xfer_lock;

  tag_t             tag_s1;
  tag_t             tag_s2;

  cost_arb_rr u_rr (
    .req      ({req1, req0}),
    .last_gnt (last_gnt),
    .gnt      (rr_gnt)
  );

  // Grant: round-robin when free, only the owner while locked, nothing in reset
  always_comb begin
    gnt_v = 2'b00;
    if (!RST) begin
      case (state)
        FREE:    gnt_v = rr_gnt;
        LOCK0:   gnt_v = {1'b0, req0};
        LOCK1:   gnt_v = {req1, 1'b0};
        default: gnt_v = 2'b00;
      endcase
    end
  end

  assign gnt0      = gnt_v[0];
  assign gnt1      = gnt_v[1];
  assign xfer      = gnt_v[0] | gnt_v[1];
  assign xfer_id   = gnt_v[1];
  assign xfer_lock = xfer_id ? lock1 : lock0;
  assign beat_inc  = beat_cnt + CNT_W'(1);

  // Ownership FSM: lock on a locked transfer, release on unlock or burst limit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FREE;
      last_gnt <= 1'b1;
      beat_cnt <= '0;
    end else if (xfer) begin
      last_gnt <= xfer_id;
      case (state)
        FREE: begin
          // A one-beat limit means a lock can never outlive its first beat
          if (xfer_lock && (MAX_BURST > 1)) begin
            state    <= xfer_id ? LOCK1 : LOCK0;
            beat_cnt <= CNT_W'(1);
          end
        end
        LOCK0, LOCK1: begin
          if (!xfer_lock || (beat_inc == CNT_W'(MAX_BURST))) begin
            state    <= FREE;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_inc;
          end
        end
        default: begin
          state    <= FREE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Read pipeline: address stage, then data stage, with the tag riding along
  always_ff @(posedge CLK) begin
    if (RST) begin
      W            <= '0;
      J            <= '0;
      rdata        <= '0;
      tag_s1.valid <= 1'b0;
      tag_s1.id    <= 1'b0;
      tag_s2.valid <= 1'b0;
      tag_s2.id    <= 1'b0;
    end else begin
      tag_s1.valid <= xfer;
      tag_s1.id    <= xfer_id;
      tag_s2       <= tag_s1;
      if (xfer) begin
        W <= xfer_id ? W1 : W0;
        J <= xfer_id ? J1 : J0;
      end
      // Capture only for a live read so rdata holds between responses
      if (tag_s1.valid) begin
        rdata <= Cost;
      end
    end
  end

  assign rvalid0 = tag_s2.valid & ~tag_s2.id;
  assign rvalid1 = tag_s2.valid &  tag_s2.id;

endmodule
`default_nettype wire
